// File: rtl/mem_bus_master_if.sv
// CPU-side command port and memory handshake signals of mem_bus_master.
// The shared Data bus stays a plain inout on the module.
interface mem_bus_master_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [19:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic [19:0] addr;
    logic        rrq;
    logic        wrq;
    logic        ack;
    logic        ok;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ok,
        output cpu_rdata, cpu_busy, cpu_done, cpu_err, addr, rrq, wrq, ack
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ok,
        input  cpu_rdata, cpu_busy, cpu_done, cpu_err, addr, rrq, wrq, ack
    );
endinterface

// File: rtl/mem_bus_master.sv
// Bus master running the RRq/WRq/OK/Ack handshake of the asynchronous 20-bit/16-bit
// memory for single-word CPU commands, with a 2-flop OK synchronizer and a timeout.
module mem_bus_master #(
    parameter int MIN_WAIT       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_bus_master_if.master bus,
    inout  wire  [15:0]      data
);
    localparam logic [7:0] MIN_WAIT_C = 8'(MIN_WAIT);
    localparam logic [7:0] LAST_WAIT  = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, REQ, ACK} state_t;

    state_t      state, state_next;
    logic        we_q, err_q;
    logic [19:0] addr_q;
    logic [15:0] wdata_q, rdata_q;
    logic [7:0]  wait_cnt;
    logic        ok_s1, ok_s2;
    logic        ok_hit, timed_out, data_oe;

    // OK only counts once the stale value from a previous access has been flushed
    assign ok_hit    = (wait_cnt >= MIN_WAIT_C) && ok_s2;
    assign timed_out = (wait_cnt == LAST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.rrq       = 1'b0;
        bus.wrq       = 1'b0;
        bus.ack       = 1'b0;
        bus.cpu_busy  = 1'b1;
        bus.cpu_done  = 1'b0;
        bus.cpu_err   = 1'b0;
        data_oe       = 1'b0;
        case (state)
            IDLE: begin
                bus.cpu_busy = 1'b0;
                if (bus.cpu_req) state_next = SETUP;
            end
            SETUP: begin
                data_oe    = we_q;
                state_next = REQ;
            end
            REQ: begin
                bus.rrq = !we_q;
                bus.wrq = we_q;
                data_oe = we_q;
                if (ok_hit || timed_out) state_next = ACK;
            end
            ACK: begin
                bus.ack      = 1'b1;
                bus.cpu_done = 1'b1;
                bus.cpu_err  = err_q;
                data_oe      = we_q;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch, wait counter, read capture and the OK synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
            ok_s1    <= 1'b0;
            ok_s2    <= 1'b0;
        end else begin
            ok_s1 <= bus.ok;
            ok_s2 <= ok_s1;
            if (state == IDLE && bus.cpu_req) begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
                err_q   <= 1'b0;
            end
            if (state == REQ) begin
                wait_cnt <= wait_cnt + 8'd1;
                if (ok_hit) begin
                    if (!we_q) rdata_q <= data;
                end else if (timed_out) begin
                    err_q <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign bus.addr      = addr_q;
    assign bus.cpu_rdata = rdata_q;
    assign data          = data_oe ? wdata_q : 16'bz;
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Synchronous bus master between the CPU core and the asynchronous 20-bit/16-bit memory. Accepts single-word read/write commands on a clocked CPU-side port and runs the memory's RRq/WRq/OK/Ack handshake, with an OK synchronizer and a timeout. Drives the shared tristate Data bus only during writes.

## Interface
- MinWait, default 2: cycles after RRq/WRq rises during which OK is ignored; legal range 2–15.
- TimeoutCycles, default 255: maximum cycles with RRq/WRq high before abort; 8-bit, must exceed MinWait.
- Clk  in  1  single system clock, rising edge.
- nRst  in  1  asynchronous, active-low reset.
- CpuReq  in  1  command valid; sampled only when CpuBusy=0.
- CpuWe  in  1  1=write, 0=read; sampled with CpuReq.
- CpuAddr  in  20  word address; sampled with CpuReq.
- CpuWData  in  16  write data; sampled with CpuReq.
- CpuRData  out  16  registered read data; valid from CpuDone onward.
- CpuBusy  out  1  command in flight.
- CpuDone  out  1  one-cycle completion pulse.
- CpuErr  out  1  one-cycle pulse coincident with CpuDone on timeout.
- Addr  out  20  memory address.
- RRq  out  1  memory read request.
- WRq  out  1  memory write request.
- Ack  out  1  one-cycle acknowledge to memory.
- Data  inout  16  shared bus; driven by this block only when its write enable is high, else Z.
- OK  in  1  memory completion, asynchronous to Clk.

## Operation
- States: IDLE, SETUP, REQ, ACK.
- IDLE: CpuReq=1 latches CpuWe, CpuAddr, CpuWData → SETUP.
- SETUP (1 cycle): Addr driven; for writes, Data driven with latched write data. RRq=WRq=0 → REQ.
- REQ: RRq (read) or WRq (write) high; wait counter starts at 0 and increments each cycle.
  - Counter < MinWait: OK ignored.
  - Counter ≥ MinWait and synchronized OK=1: reads capture Data into CpuRData; → ACK.
  - Counter reaches TimeoutCycles without qualifying OK: → ACK with error flag set; CpuRData unchanged.
- ACK (1 cycle): RRq=WRq=0, Ack=1, CpuDone=1, CpuErr=error flag. Addr held. Write data held on Data this cycle (hold time), released at cycle end → IDLE.
- OK passes through a 2-flop synchronizer; the raw OK input is never used. The responder may leave OK high between transactions; MinWait ≥ 2 guarantees a stale OK is flushed before sampling.
- RRq and WRq are never high together. Data is never driven while RRq=1.
- CpuReq during CpuBusy=1 is ignored, not queued; the requester re-presents it.
- CpuReq in the ACK cycle is ignored; the earliest next accept is the IDLE cycle after ACK.

## Timing
- Reset (async, immediate on nRst=0): state IDLE; Addr=0, RRq=0, WRq=0, Ack=0, Data=Z, CpuRData=0, CpuBusy=0, CpuDone=0, CpuErr=0; synchronizer flops and counter 0.
- Reset mid-transaction: requests drop and Data goes Z without waiting for a clock edge. No CpuDone is issued for the aborted command.
- Read with OK already high, command accepted at edge of cycle 0:
  - SETUP in cycle 1; RRq high cycles 2–4.
  - Capture at the end of cycle 4 (counter=2); ACK/CpuDone in cycle 5; IDLE in cycle 6.
  - CpuBusy high cycles 1–5.
- General latency: accept → CpuDone = 3 + max(MinWait, cycles until synchronized OK=1).
- Timeout: RRq/WRq high for exactly TimeoutCycles cycles, then ACK with CpuErr=1.
- Address/data setup to request rise = 1 cycle. Write data hold after WRq falls = 1 cycle.

## Test plan
- Read, memory word 0x00010 = 0xBEEF, OK responds immediately → RRq high 3 cycles, CpuRData=0xBEEF, CpuDone in cycle 5, CpuErr=0, Data=Z throughout from this side.
- Write 0x1234 to 0xFFFFF, then read 0xFFFFF → WRq asserted one cycle after Data=0x1234 is stable; Data held through ACK; readback returns 0x1234.
- OK delayed 10 cycles after RRq rises; OK held high from the previous access → no early capture at counter=2; capture occurs after the new OK pulse is synchronized.
- OK tied low, TimeoutCycles=255 → RRq high exactly 255 cycles, then CpuDone=CpuErr=1 and CpuRData unchanged.
- CpuReq held high continuously with alternating commands → one accept per 6 cycles; commands presented while busy are dropped.
- nRst pulsed low during REQ of a write → WRq=0 and Data=Z immediately, no CpuDone; the next command after reset completes normally.
